// File: rtl/ft_pkg.sv
// Fault-tolerance checkpoint package.
// Holds the recovery FSM state encoding and default widths.
package ft_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_RESET,
    ST_RESTORE,
    ST_RESUME
  } state_t;

endpackage

// File: rtl/ft_checkpoint_rf.sv
// Checkpoint register file: one sync write port, one async read port.
// Ports: clk, rst (sync, clears all entries), we/waddr/wdata, raddr/rdata.
import ft_pkg::*;

module ft_checkpoint_rf #(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ft_module.sv
// Lockstep fault-tolerance unit: checkpoints good writes and PC, and on a
// core A/B mismatch halts, resets and replays the register file to the cores.
// Ports: clk_i, rst_i; core A/B write ports; spc_i/spc_o PC checkpoint;
// addr_o/data_o restore stream; halt_o, resume_o, shift_o, reset_o controls.
import ft_pkg::*;

module ft_module #(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = 2 ** ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  input  logic [DATA_WIDTH-1:0] spc_i,
  output logic [DATA_WIDTH-1:0] spc_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  halt_o,
  output logic                  resume_o,
  output logic                  shift_o,
  output logic                  reset_o
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  mismatch;
  logic                  good;
  logic                  idle;

  assign mismatch = (we_a_i != we_b_i) ||
                    (we_a_i && we_b_i &&
                     ((addr_a_i != addr_b_i) ||
                      (data_a_i != data_b_i)));
  assign good = we_a_i && we_b_i && !mismatch;
  assign idle = (state == ST_IDLE);

  // Writes land only while the cores are trusted (IDLE).
  ft_checkpoint_rf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rf (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (idle && good),
    .waddr (addr_a_i),
    .wdata (data_a_i),
    .raddr (cnt),
    .rdata (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mismatch) state <= ST_HALT;
          else          pc    <= spc_i;
        end
        ST_HALT:  state <= ST_RESET;
        ST_RESET: state <= ST_RESTORE;
        ST_RESTORE: begin
          // Counter wraps to 0 naturally on the last entry.
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= ST_RESUME;
        end
        ST_RESUME: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign halt_o   = (state == ST_HALT) ||
                    (state == ST_RESET) ||
                    (state == ST_RESTORE);
  assign reset_o  = (state == ST_RESET);
  assign shift_o  = (state == ST_RESTORE);
  assign resume_o = (state == ST_RESUME);
  assign addr_o   = shift_o ? cnt : '0;
  assign data_o   = shift_o ? rdata : '0;
  assign spc_o    = pc;

endmodule

// File: tb/tb_ft_module.sv
// Randomized self-checking bench for ft_module.
// Reference model tracks recovery as a phase count since HALT entry.
module tb_ft_module;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        we_a_i, we_b_i;
  logic [4:0]  addr_a_i, addr_b_i;
  logic [31:0] data_a_i, data_b_i;
  logic [31:0] spc_i;
  logic [31:0] spc_o;
  logic [4:0]  addr_o;
  logic [31:0] data_o;
  logic        halt_o, resume_o, shift_o, reset_o;

  int n_chk = 0;
  int n_fail = 0;

  // Model: phase -1 = normal running, 0..34 = cycles since HALT entry.
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  int          phase;

  ft_module dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .we_a_i   (we_a_i),
    .we_b_i   (we_b_i),
    .addr_a_i (addr_a_i),
    .addr_b_i (addr_b_i),
    .data_a_i (data_a_i),
    .data_b_i (data_b_i),
    .spc_i    (spc_i),
    .spc_o    (spc_o),
    .addr_o   (addr_o),
    .data_o   (data_o),
    .halt_o   (halt_o),
    .resume_o (resume_o),
    .shift_o  (shift_o),
    .reset_o  (reset_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit mm;
    mm = (we_a_i != we_b_i) ||
         (we_a_i && we_b_i &&
          (addr_a_i != addr_b_i || data_a_i != data_b_i));
    if (rst_i) begin
      phase = -1;
      m_pc  = 0;
      foreach (m_rf[i]) m_rf[i] = 0;
    end else if (phase < 0) begin
      if (mm) begin
        phase = 0;
      end else begin
        if (we_a_i && we_b_i) m_rf[addr_a_i] = data_a_i;
        m_pc = spc_i;
      end
    end else begin
      phase = (phase == 34) ? -1 : phase + 1;
    end
  endtask

  task automatic check_outs();
    bit sh;
    sh = (phase >= 2 && phase <= 33);
    chk("halt",   halt_o,   phase >= 0 && phase <= 33);
    chk("reset",  reset_o,  phase == 1);
    chk("shift",  shift_o,  sh);
    chk("resume", resume_o, phase == 34);
    chk("addr",   addr_o,   sh ? phase - 2 : 0);
    chk("data",   data_o,   sh ? m_rf[phase - 2] : 32'd0);
    chk("spc",    spc_o,    m_pc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic drive(input logic r, input logic wa, input logic wb,
                       input logic [4:0] aa, input logic [4:0] ab,
                       input logic [31:0] da, input logic [31:0] db,
                       input logic [31:0] pc);
    rst_i = r;
    we_a_i = wa; we_b_i = wb;
    addr_a_i = aa; addr_b_i = ab;
    data_a_i = da; data_b_i = db;
    spc_i = pc;
  endtask

  task automatic idle_n(input int n, input logic [31:0] pc);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, pc);
      step();
    end
  endtask

  initial begin
    int mode;
    logic [4:0]  a;
    logic [31:0] d;
    phase = -1;
    m_pc = 0;
    foreach (m_rf[i]) m_rf[i] = 0;

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    // Fill the checkpoint file with i*10.
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 1, 5'(i), 5'(i), i * 10, i * 10, 32'h80);
      step();
    end

    // Single-sided write enable triggers a full replay.
    drive(0, 1, 0, 0, 0, 0, 0, 32'h98);
    step();
    idle_n(36, 32'h80);

    // Data disagreement at address 10 must not corrupt the entry.
    drive(0, 1, 1, 10, 10, 100, 100, 32'h84);
    step();
    drive(0, 1, 1, 10, 10, 100, 143, 32'h88);
    step();
    idle_n(36, 32'h8c);

    // Persistent mismatch restarts recovery immediately.
    for (int i = 0; i < 80; i++) begin
      drive(0, 0, 1, 3, 3, 7, 7, 32'h90);
      step();
    end
    idle_n(36, 32'h94);

    // Reset in the middle of RESTORE, then replay a cleared file.
    drive(0, 1, 1, 4, 9, 1, 1, 32'h99);
    step();
    idle_n(20, 32'h9c);
    drive(1, 1, 0, 0, 0, 0, 0, 32'ha0);
    step();
    idle_n(1, 32'ha4);
    drive(0, 1, 0, 0, 0, 0, 0, 32'ha8);
    step();
    idle_n(36, 32'hac);

    // Random traffic with occasional faults and resets.
    for (int i = 0; i < 2500; i++) begin
      mode = $urandom_range(0, 39);
      a = 5'($urandom);
      d = $urandom;
      case (mode)
        0: drive(0, 1, 0, a, a, d, d, $urandom);
        1: drive(0, 0, 1, a, a, d, d, $urandom);
        2: drive(0, 1, 1, a, a ^ 5'($urandom_range(1, 31)),
                 d, d, $urandom);
        3: drive(0, 1, 1, a, a, d, d ^ 32'($urandom_range(1, 255)),
                 $urandom);
        4: drive($urandom_range(0, 7) == 0, 1, 1, a, a, d, d,
                 $urandom);
        default:
          if (mode < 28) drive(0, 1, 1, a, a, d, d, $urandom);
          else           drive(0, 0, 0, a, 5'($urandom),
                               d, $urandom, $urandom);
      endcase
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ft_module.md
FT_MODULE -- requirements
Module: ft_module

Interface
REQ-001 Parameter ADDR_WIDTH, default 5: register-file address width.
REQ-002 Parameter DATA_WIDTH, default 2**ADDR_WIDTH (32): data and PC width.
REQ-003 clk_i  input  1: single clock; all state updates on rising edge.
REQ-004 rst_i  input  1: reset, synchronous and active-high.
REQ-005 we_a_i, we_b_i  input  1 each: register write enables of lockstep cores A and B.
REQ-006 addr_a_i, addr_b_i  input  ADDR_WIDTH each: write addresses of cores A and B.
REQ-007 data_a_i, data_b_i  input  DATA_WIDTH each: write data of cores A and B.
REQ-008 spc_i  input  DATA_WIDTH: current core PC, offered for checkpointing.
REQ-009 spc_o  output  DATA_WIDTH: checkpointed PC (last good PC) for core restart.
REQ-010 addr_o, data_o  output  ADDR_WIDTH / DATA_WIDTH: restore address and data driven to the cores.
REQ-011 halt_o, resume_o, shift_o, reset_o  output  1 each: core halt, core resume, restore-data-valid strobe, core reset.

Function
REQ-012 Mismatch SHALL be defined as we_a_i!=we_b_i, or (we_a_i&&we_b_i&&(addr_a_i!=addr_b_i||data_a_i!=data_b_i)); combinational.
REQ-013 Good write SHALL be defined as we_a_i&&we_b_i&&!mismatch.
REQ-014 The block SHALL hold a 2**ADDR_WIDTH x DATA_WIDTH checkpoint register file; all addresses are writable, including 0.
REQ-015 In IDLE, a good write SHALL store data_a_i at addr_a_i on the same edge.
REQ-016 In IDLE with no mismatch, spc_i SHALL be captured into the PC checkpoint on every edge; on mismatch, the checkpoint SHALL hold its value.
REQ-017 The FSM SHALL have states IDLE, HALT, RESET, RESTORE and RESUME.
REQ-018 IDLE->HALT SHALL occur on the edge at which a mismatch is sampled; the register file and PC SHALL NOT update on that edge.
REQ-019 HALT->RESET, RESET->RESTORE and RESUME->IDLE SHALL each occur after exactly 1 cycle.
REQ-020 RESTORE SHALL last exactly 2**ADDR_WIDTH cycles, with a counter stepping 0..31; RESTORE->RESUME SHALL occur when the counter is 31, and the counter SHALL wrap to 0.
REQ-021 Outputs SHALL be Moore, decoded from the state.
REQ-022 halt_o SHALL be 1 in HALT, RESET and RESTORE.
REQ-023 reset_o SHALL be 1 only in RESET.
REQ-024 shift_o SHALL be 1 only in RESTORE.
REQ-025 resume_o SHALL be 1 only in RESUME.
REQ-026 In RESTORE, addr_o SHALL equal the counter and data_o SHALL equal regfile[counter]; otherwise both SHALL be 0.
REQ-027 spc_o SHALL always show the PC checkpoint.
REQ-028 Outside IDLE, core inputs SHALL be ignored: no writes, no PC capture, no re-triggering.
REQ-029 Total recovery SHALL be 35 cycles from HALT entry to return to IDLE.
REQ-030 If a mismatch is still present in the first IDLE cycle after RESUME, recovery SHALL restart.

Reset
REQ-031 While rst_i=1 at an edge: state SHALL become IDLE; the counter, PC checkpoint and all register-file entries SHALL become 0.
REQ-032 After reset, all outputs SHALL be 0.
REQ-033 Reset SHALL override any state, including mid-RESTORE.

Structure
REQ-034 Package ft_pkg SHALL hold the FSM state enum and the default width constants.
REQ-035 Sub-module ft_checkpoint_rf SHALL implement the register file: one synchronous write port and one asynchronous read port.

Verification
REQ-036 Reset, then good writes regfile[i]=i*10 for i=0..31 with spc_i=0x80 -> no control outputs asserted; spc_o=0x80.
REQ-037 we_a=1, we_b=0, spc_i=0x98 -> next cycle halt_o=1; following cycle reset_o=1; spc_o stays 0x80.
REQ-038 During RESTORE -> 32 cycles with shift_o=1 and addr_o/data_o = 0/0, 1/10 ... 31/310; then 1 cycle resume_o=1 with spc_o=0x80.
REQ-039 Same addresses (10), data 100 vs 143 -> recovery sequence; regfile[10] remains 100.
REQ-040 Mismatch held for 35+ cycles -> recovery restarts in the first IDLE cycle.
REQ-041 rst_i asserted mid-RESTORE -> next cycle in IDLE with all outputs 0 and regfile cleared.
